// File: rtl/cnn_ahb_result_regs.sv
// AHB-Lite register bank and result FIFO for the CNN accelerator: control/status, frame counter,
// head-frame readout and a maskable IRQ.
module cnn_ahb_result_regs #(
  parameter int unsigned DW    = 16,
  parameter int unsigned N_OUT = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HADDR,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  CNN_RSTn,
  input  logic                  RES_VALID,
  input  logic [N_OUT*DW-1:0]   RES_DATA,
  output logic                  IRQ
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned IdxW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned FrameW = N_OUT * DW;
  localparam logic [11:0] OutEnd = 12'(16 + 4 * N_OUT);

  typedef enum logic [2:0] {SelNone, SelCtrl, SelStat, SelPop, SelFcnt, SelOut} sel_e;

  sel_e            sel_d, sel_q;
  logic            write_d, write_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic [11:0]     off, out_off;

  logic            srst_d, srst_q, en_d, en_q, irq_en_d, irq_en_q;
  logic            done_d, done_q, ovf_d, ovf_q, irq_d, irq_q;
  logic [PtrW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic [31:0]     fcnt_d, fcnt_q;
  logic [FrameW-1:0] mem_q [DEPTH];

  logic wr_ctrl, wr_stat, wr_pop;
  logic flush, empty, full, push_req, do_push, do_pop, ovf_set;
  logic [FrameW-1:0] head_frame;
  logic signed [DW-1:0] head_val;
  logic [31:0] stat;
  logic unused_bits;

  assign unused_bits = ^{HADDR[31:16], HTRANS[0], HWDATA[31:4], HWDATA[1]};

  // Address-phase decode; only word-aligned offsets in the 0x1xxx window are mapped.
  always_comb begin
    sel_d   = SelNone;
    idx_d   = '0;
    write_d = 1'b0;
    off     = HADDR[11:0];
    out_off = off - 12'h010;
    if (HSEL && HREADY && HTRANS[1] && (HADDR[15:12] == 4'h1) && (off[1:0] == 2'b00)) begin
      write_d = HWRITE;
      if (off == 12'h000) begin
        sel_d = SelCtrl;
      end else if (off == 12'h004) begin
        sel_d = SelStat;
      end else if (off == 12'h008) begin
        sel_d = SelPop;
      end else if (off == 12'h00C) begin
        sel_d = SelFcnt;
      end else if ((off >= 12'h010) && (off < OutEnd)) begin
        sel_d = SelOut;
        idx_d = out_off[IdxW+1:2];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sel_q   <= SelNone;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      write_q <= write_d;
      idx_q   <= idx_d;
    end
  end

  assign wr_ctrl = write_q && (sel_q == SelCtrl);
  assign wr_stat = write_q && (sel_q == SelStat);
  assign wr_pop  = write_q && (sel_q == SelPop);

  assign flush    = srst_q | ~en_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign push_req = RES_VALID & ~flush;
  assign do_pop   = wr_pop & ~empty & ~flush;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push_req & (~full | do_pop);
  assign ovf_set  = push_req & full & ~do_pop;

  always_comb begin
    srst_d   = 1'b0;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl) begin
      srst_d   = HWDATA[0];
      en_d     = HWDATA[2];
      irq_en_d = HWDATA[3];
    end

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      wptr_d  = wptr_q + PtrW'(do_push);
      rptr_d  = rptr_q + PtrW'(do_pop);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      if (do_push) begin
        done_d = 1'b1;
      end else if (wr_stat && HWDATA[0]) begin
        done_d = 1'b0;
      end
      if (ovf_set) begin
        ovf_d = 1'b1;
      end else if (wr_stat && HWDATA[3]) begin
        ovf_d = 1'b0;
      end
    end

    fcnt_d = fcnt_q;
    if (srst_q) begin
      fcnt_d = '0;
    end else if (do_push) begin
      fcnt_d = fcnt_q + 32'd1;
    end

    irq_d = irq_en_q & (done_q | ovf_q);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      srst_q   <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      srst_q   <= srst_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Frame storage needs no reset: entries are only visible while counted.
  always_ff @(posedge HCLK) begin
    if (do_push) begin
      mem_q[wptr_q] <= RES_DATA;
    end
  end

  assign head_frame = mem_q[rptr_q];
  assign head_val   = head_frame[int'(idx_q) * DW +: DW];

  always_comb begin
    stat       = '0;
    stat[0]    = done_q;
    stat[1]    = empty;
    stat[2]    = full;
    stat[3]    = ovf_q;
    stat[12:8] = 5'(count_q);

    HRDATA = '0;
    if (!write_q) begin
      case (sel_q)
        SelCtrl: HRDATA = {28'h0, irq_en_q, en_q, 1'b0, srst_q};
        SelStat: HRDATA = stat;
        SelFcnt: HRDATA = fcnt_q;
        SelOut:  HRDATA = empty ? 32'h0 : 32'(head_val);
        default: HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign CNN_RSTn  = HRESETn & ~srst_q & en_q;
  assign IRQ       = irq_q;

endmodule

// File: tb/tb_cnn_ahb_result_regs.sv
// Self-checking bench for cnn_ahb_result_regs: table-driven bus accesses with a read scoreboard,
// plus hand-timed sequences for IRQ latency, same-edge push/pop and the SRST pulse.
module tb_cnn_ahb_result_regs;

  localparam int unsigned DW    = 16;
  localparam int unsigned N_OUT = 6;
  localparam int unsigned DEPTH = 4;

  logic               HCLK = 1'b0;
  logic               HRESETn, HSEL, HREADY, HWRITE;
  logic [1:0]         HTRANS;
  logic [31:0]        HADDR, HWDATA, HRDATA;
  logic               HREADYOUT, CNN_RSTn, RES_VALID, IRQ;
  logic [N_OUT*DW-1:0] RES_DATA;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          grp;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;  // write data, or expected read data
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_exp[$];
  string       sb_name[$];

  cnn_ahb_result_regs #(.DW(DW), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .CNN_RSTn  (CNN_RSTn),
    .RES_VALID (RES_VALID),
    .RES_DATA  (RES_DATA),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] fval(input int f, input int i);
    logic [15:0] v;
    v = 16'(f * 256 + i * 17);
    if (f % 2 == 1) v = ~v;
    return v;
  endfunction

  function automatic logic [31:0] fexp(input int f, input int i);
    logic [15:0] v;
    v = fval(f, i);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [N_OUT*DW-1:0] frame(input int f);
    logic [N_OUT*DW-1:0] d;
    for (int i = 0; i < N_OUT; i++) d[i*DW +: DW] = fval(f, i);
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {16'h0, addr};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] e;
    string       n;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {16'h0, addr};
    sb_exp.push_back(exp);
    sb_name.push_back(name);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    e = sb_exp.pop_front();
    n = sb_name.pop_front();
    check(n, HRDATA, e);
  endtask

  task automatic push_frame(input logic [N_OUT*DW-1:0] d);
    @(negedge HCLK);
    RES_VALID = 1'b1; RES_DATA = d;
    @(negedge HCLK);
    RES_VALID = 1'b0;
  endtask

  task automatic run_group(input int g);
    foreach (vecs[k]) begin
      if (vecs[k].grp == g) begin
        if (vecs[k].wr) bus_write(vecs[k].addr, vecs[k].data);
        else bus_read(vecs[k].addr, vecs[k].data, vecs[k].name);
      end
    end
  endtask

  initial begin
    logic [N_OUT*DW-1:0] f0;

    vecs.push_back('{1, 1'b0, 16'h1000, 32'h0000_0000, "rst_ctrl"});
    vecs.push_back('{1, 1'b0, 16'h1004, 32'h0000_0002, "rst_stat"});
    vecs.push_back('{1, 1'b0, 16'h100C, 32'h0000_0000, "rst_fcnt"});
    vecs.push_back('{1, 1'b0, 16'h1010, 32'h0000_0000, "rst_out0"});
    vecs.push_back('{2, 1'b0, 16'h1010, 32'hFFFF_FFF3, "t2_out0"});
    vecs.push_back('{2, 1'b0, 16'h1024, 32'h0000_0042, "t2_out5"});
    vecs.push_back('{2, 1'b0, 16'h1014, 32'h0000_0100, "t2_out1"});
    vecs.push_back('{2, 1'b0, 16'h1004, 32'h0000_0101, "t2_stat"});
    vecs.push_back('{2, 1'b0, 16'h100C, 32'h0000_0001, "t2_fcnt"});
    vecs.push_back('{3, 1'b0, 16'h1004, 32'h0000_040D, "t3_stat_full"});
    vecs.push_back('{3, 1'b0, 16'h100C, 32'h0000_0004, "t3_fcnt"});
    vecs.push_back('{3, 1'b0, 16'h1010, fexp(1, 0), "t3_out0_f1"});
    vecs.push_back('{3, 1'b0, 16'h101C, fexp(1, 3), "t3_out3_f1"});
    vecs.push_back('{4, 1'b0, 16'h1004, 32'h0000_0309, "t3_stat_pop"});
    vecs.push_back('{4, 1'b0, 16'h1010, fexp(2, 0), "t3_out0_f2"});
    vecs.push_back('{5, 1'b0, 16'h1004, 32'h0000_0405, "t4_stat"});
    vecs.push_back('{5, 1'b0, 16'h100C, 32'h0000_0006, "t4_fcnt"});
    vecs.push_back('{5, 1'b0, 16'h1010, fexp(3, 0), "t4_out0_f3"});
    vecs.push_back('{6, 1'b0, 16'h1004, 32'h0000_040D, "t5_stat_ovf"});
    vecs.push_back('{6, 1'b0, 16'h100C, 32'h0000_0006, "t5_fcnt_drop"});
    vecs.push_back('{7, 1'b0, 16'h1004, 32'h0000_0404, "t5_stat_w1c"});
    for (int p = 0; p < 5; p++) vecs.push_back('{8, 1'b1, 16'h1008, 32'h0, "pop"});
    vecs.push_back('{8, 1'b0, 16'h1004, 32'h0000_0002, "t5_stat_empty"});
    vecs.push_back('{8, 1'b0, 16'h1010, 32'h0000_0000, "t5_out0_empty"});
    vecs.push_back('{8, 1'b1, 16'h17FC, 32'hFFFF_FFFF, "wr_unmapped"});
    vecs.push_back('{8, 1'b0, 16'h17FC, 32'h0000_0000, "t5_rd_unmapped"});
    vecs.push_back('{8, 1'b1, 16'h2000, 32'h0000_0000, "wr_other_page"});
    vecs.push_back('{8, 1'b0, 16'h1000, 32'h0000_000C, "t5_ctrl_kept"});
    vecs.push_back('{8, 1'b0, 16'h1004, 32'h0000_0002, "t5_stat_kept"});
    vecs.push_back('{8, 1'b0, 16'h100C, 32'h0000_0006, "t5_fcnt_kept"});
    vecs.push_back('{9, 1'b0, 16'h1004, 32'h0000_0002, "t6_stat"});
    vecs.push_back('{9, 1'b0, 16'h100C, 32'h0000_0000, "t6_fcnt"});
    vecs.push_back('{9, 1'b0, 16'h1000, 32'h0000_0004, "t6_ctrl"});
    vecs.push_back('{10, 1'b0, 16'h1004, 32'h0000_0002, "en0_stat"});
    vecs.push_back('{10, 1'b0, 16'h100C, 32'h0000_0001, "en0_fcnt"});
    vecs.push_back('{10, 1'b0, 16'h1000, 32'h0000_0000, "en0_ctrl"});

    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = '0; HWDATA = '0; RES_VALID = 1'b0; RES_DATA = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    check("rst_cnn_rstn", {31'h0, CNN_RSTn}, 32'h0);
    check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    run_group(1);

    // Enable, one frame, IRQ two edges after the push
    bus_write(16'h1000, 32'h0000_000C);
    for (int i = 0; i < N_OUT; i++) f0[i*DW +: DW] = 16'(i * 256);
    f0[0 +: DW] = 16'hFFF3;
    f0[5*DW +: DW] = 16'h0042;
    push_frame(f0);
    check("t2_irq_early", {31'h0, IRQ}, 32'h0);
    @(negedge HCLK);
    check("t2_irq", {31'h0, IRQ}, 32'h1);
    run_group(2);

    // Flush via SRST (IRQ_EN kept), then fill past DEPTH
    bus_write(16'h1000, 32'h0000_000D);
    @(negedge HCLK);
    for (int f = 1; f <= 5; f++) push_frame(frame(f));
    run_group(3);
    bus_write(16'h1008, 32'h0);
    run_group(4);

    // Clear OVF, refill, then push on the POP data-phase edge while full
    bus_write(16'h1004, 32'h0000_0008);
    push_frame(frame(6));
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b11; HWRITE = 1'b1; HADDR = 32'h0000_1008;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0;
    RES_VALID = 1'b1; RES_DATA = frame(7);
    @(negedge HCLK);
    RES_VALID = 1'b0;
    run_group(5);

    // Overflow, W1C of both flags, IRQ drop latency, empty pops, unmapped accesses
    push_frame(frame(8));
    run_group(6);
    check("t5_irq_set", {31'h0, IRQ}, 32'h1);
    bus_write(16'h1004, 32'h0000_0009);
    @(negedge HCLK);
    check("t5_irq_hold", {31'h0, IRQ}, 32'h1);
    @(negedge HCLK);
    check("t5_irq_drop", {31'h0, IRQ}, 32'h0);
    run_group(7);
    run_group(8);

    // SRST with EN: one-cycle core reset pulse, queue and counter flushed
    for (int f = 9; f <= 11; f++) push_frame(frame(f));
    bus_write(16'h1000, 32'h0000_0005);
    check("t6_rstn_before", {31'h0, CNN_RSTn}, 32'h1);
    @(negedge HCLK);
    check("t6_rstn_pulse", {31'h0, CNN_RSTn}, 32'h0);
    @(negedge HCLK);
    check("t6_rstn_after", {31'h0, CNN_RSTn}, 32'h1);
    check("t6_irq", {31'h0, IRQ}, 32'h0);
    run_group(9);

    // EN=0 flushes and ignores results but keeps FCNT
    push_frame(frame(12));
    bus_write(16'h1000, 32'h0000_0000);
    @(negedge HCLK);
    push_frame(frame(13));
    check("en0_cnn_rstn", {31'h0, CNN_RSTn}, 32'h0);
    run_group(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
